lfsr: RTL and testbench
=======================

LFSR -- requirements
Module: lfsr

Interface
REQ-001 SHALL have parameter N, default 4, meaning register width in bits; legal range 2..32 (elaboration error otherwise).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port load_seed  input  1  when high, load seed_data into the register instead of shifting.
REQ-005 SHALL have port seed_data  input  N  seed value, sampled only when load_seed is high.
REQ-006 SHALL have port lfsr_data  output  N  current LFSR state, registered.
REQ-007 SHALL have port lfsr_done  output  1  registered flag, high while the state has returned to the seed after a full period.

Function
REQ-008 SHALL be a Fibonacci LFSR with XOR feedback, shifting left: next = {lfsr_data[N-2:0], fb}, where fb = XOR of lfsr_data bits selected by the tap mask for N.
REQ-009 SHALL use maximal-length taps so the period is 2^N-1 for every nonzero seed; N=4 taps are bits 3 and 2 (x^4+x^3+1).
REQ-010 SHALL apply the following priority each rising edge: reset_n low, then load_seed high, then shift.
REQ-011 SHALL, when load_seed is high, set lfsr_data to seed_data and capture the same value in an internal seed register; no shift occurs that cycle.
REQ-012 SHALL hold the register at the seed, without shifting, for as long as load_seed stays high.
REQ-013 SHALL, when an all-zero seed_data is loaded, substitute the value 1 (LSB set) for both lfsr_data and the seed register, so the all-zero lock-up state is never entered.
REQ-014 SHALL shift once per clock whenever reset_n is high and load_seed is low; there is no other enable.
REQ-015 SHALL set lfsr_done to 1 on a shifting edge whose next state equals the seed register, and to 0 on every other edge.
REQ-016 SHALL therefore make lfsr_done a one-cycle pulse, first asserted 2^N-1 shifts after load or reset, repeating every 2^N-1 cycles.
REQ-017 SHALL clear lfsr_done to 0 on any load edge, including a load of a value equal to the current state.

Reset
REQ-018 SHALL, on a rising edge with reset_n low, set lfsr_data to all ones, the seed register to all ones, and lfsr_done to 0.
REQ-019 SHALL make reset override load_seed and shifting, and SHALL allow reset mid-sequence with no residual state.
REQ-020 SHALL not reset asynchronously; outputs are unspecified before the first clock edge.

Structure
REQ-021 SHALL take its tap masks from shared package lfsr_pkg.
REQ-022 lfsr_pkg SHALL contain a function returning the 32-bit maximal-length tap mask for N = 2..32, plus constants LFSR_N_MIN = 2 and LFSR_N_MAX = 32.
REQ-023 SHALL be a single module with no sub-modules; the feedback XOR is a reduction over (state AND mask).

Verification
REQ-024 With N=4, hold reset_n low 1 edge -> lfsr_data = 1111 and lfsr_done = 0.
REQ-025 Release reset, load_seed = 1 with seed_data = 1111 for 2 edges, then 0 -> lfsr_data sequence 1110, 1100, 1000, 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111.
REQ-026 Under the REQ-025 stimulus, lfsr_done = 1 only in the cycle the state returns to 1111 (the 15th shift), and again every 15 cycles over 32 cycles.
REQ-027 Load seed_data = 0000 -> lfsr_data = 0001 and the sequence never reaches 0000; lfsr_done pulses after 15 shifts.
REQ-028 Assert reset_n low while both load_seed and shifting are active mid-sequence -> next state 1111, lfsr_done = 0; load wins over shift when reset_n is high.
REQ-029 For N = 2..32 (exhaustive up to N=16, sampled above that), the measured period equals 2^N-1 and no state repeats within the period.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared tap-mask table for the maximal-length Fibonacci LFSR family.
// Masks use bit i = 1 to select state bit i into the feedback XOR.
package lfsr_pkg;

  localparam int LFSR_N_MIN = 2;
  localparam int LFSR_N_MAX = 32;

  // Maximal-length tap mask for an n-bit register; zero for unsupported widths.
  function automatic logic [31:0] lfsr_taps(input int unsigned n);
    logic [31:0] mask;
    case (n)
      32'd2:   mask = 32'h0000_0003;
      32'd3:   mask = 32'h0000_0006;
      32'd4:   mask = 32'h0000_000C;
      32'd5:   mask = 32'h0000_0014;
      32'd6:   mask = 32'h0000_0030;
      32'd7:   mask = 32'h0000_0060;
      32'd8:   mask = 32'h0000_00B8;
      32'd9:   mask = 32'h0000_0110;
      32'd10:  mask = 32'h0000_0240;
      32'd11:  mask = 32'h0000_0500;
      32'd12:  mask = 32'h0000_0829;
      32'd13:  mask = 32'h0000_100D;
      32'd14:  mask = 32'h0000_2015;
      32'd15:  mask = 32'h0000_6000;
      32'd16:  mask = 32'h0000_D008;
      32'd17:  mask = 32'h0001_2000;
      32'd18:  mask = 32'h0002_0400;
      32'd19:  mask = 32'h0004_0023;
      32'd20:  mask = 32'h0009_0000;
      32'd21:  mask = 32'h0014_0000;
      32'd22:  mask = 32'h0030_0000;
      32'd23:  mask = 32'h0042_0000;
      32'd24:  mask = 32'h00E1_0000;
      32'd25:  mask = 32'h0120_0000;
      32'd26:  mask = 32'h0200_0023;
      32'd27:  mask = 32'h0400_0013;
      32'd28:  mask = 32'h0900_0000;
      32'd29:  mask = 32'h1400_0000;
      32'd30:  mask = 32'h2000_0029;
      32'd31:  mask = 32'h4800_0000;
      32'd32:  mask = 32'h8020_0003;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Left-shifting Fibonacci LFSR with seed load, zero-seed substitution and a
// one-cycle pulse each time the state returns to the loaded seed.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_seed,
  input  logic [N-1:0] seed_data,
  output logic [N-1:0] lfsr_data,
  output logic         lfsr_done
);

  if ((N < LFSR_N_MIN) || (N > LFSR_N_MAX)) begin : g_bad_width
    $error("lfsr: parameter N out of supported range 2..32");
  end

  localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));

  logic [N-1:0] data_q, data_d;
  logic [N-1:0] seed_q, seed_d;
  logic         done_q, done_d;
  logic         fb_s;
  logic [N-1:0] shift_s;
  logic [N-1:0] seed_fix_s;

  // An all-zero seed would lock the register up, so it is replaced by 1.
  always_comb begin
    fb_s       = ^(data_q & TAPS);
    shift_s    = {data_q[N-2:0], fb_s};
    seed_fix_s = (seed_data == {N{1'b0}}) ? {{(N-1){1'b0}}, 1'b1} : seed_data;
    data_d     = shift_s;
    seed_d     = seed_q;
    done_d     = 1'b0;
    if (load_seed) begin
      data_d = seed_fix_s;
      seed_d = seed_fix_s;
      done_d = 1'b0;
    end else begin
      data_d = shift_s;
      seed_d = seed_q;
      done_d = (shift_s == seed_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= {N{1'b1}};
      seed_q <= {N{1'b1}};
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      seed_q <= seed_d;
      done_q <= done_d;
    end
  end

  assign lfsr_data = data_q;
  assign lfsr_done = done_q;

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: N=4 sequences and priorities, plus period checks
// on several other widths.
module tb_lfsr;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_seed = 1'b0;
  logic [3:0]  seed_data = 4'h0;
  logic [3:0]  lfsr_data;
  logic        lfsr_done;

  logic        load_w = 1'b0;
  logic [31:0] seed_w = 32'h0;
  logic [1:0]  d2_data;   logic d2_done;
  logic [2:0]  d3_data;   logic d3_done;
  logic [6:0]  d7_data;   logic d7_done;
  logic [11:0] d12_data;  logic d12_done;
  logic [31:0] d32_data;  logic d32_done;

  int          sel_n = 2;
  logic [31:0] obs_data;
  logic        obs_done;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_seq [15] = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                               4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
  bit seen [0:4095];

  always #5 clk = ~clk;

  lfsr #(.N(4)) dut (.clk(clk), .reset_n(reset_n), .load_seed(load_seed),
                     .seed_data(seed_data), .lfsr_data(lfsr_data), .lfsr_done(lfsr_done));
  lfsr #(.N(2))  u2  (.clk(clk), .reset_n(reset_n), .load_seed(load_w),
                      .seed_data(seed_w[1:0]), .lfsr_data(d2_data), .lfsr_done(d2_done));
  lfsr #(.N(3))  u3  (.clk(clk), .reset_n(reset_n), .load_seed(load_w),
                      .seed_data(seed_w[2:0]), .lfsr_data(d3_data), .lfsr_done(d3_done));
  lfsr #(.N(7))  u7  (.clk(clk), .reset_n(reset_n), .load_seed(load_w),
                      .seed_data(seed_w[6:0]), .lfsr_data(d7_data), .lfsr_done(d7_done));
  lfsr #(.N(12)) u12 (.clk(clk), .reset_n(reset_n), .load_seed(load_w),
                      .seed_data(seed_w[11:0]), .lfsr_data(d12_data), .lfsr_done(d12_done));
  lfsr #(.N(32)) u32 (.clk(clk), .reset_n(reset_n), .load_seed(load_w),
                      .seed_data(seed_w), .lfsr_data(d32_data), .lfsr_done(d32_done));

  always_comb begin
    obs_data = 32'h0;
    obs_done = 1'b0;
    case (sel_n)
      2:       begin obs_data = 32'(d2_data);  obs_done = d2_done;  end
      3:       begin obs_data = 32'(d3_data);  obs_done = d3_done;  end
      7:       begin obs_data = 32'(d7_data);  obs_done = d7_done;  end
      12:      begin obs_data = 32'(d12_data); obs_done = d12_done; end
      default: begin obs_data = d32_data;      obs_done = d32_done; end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_seed = 1'b0; seed_data = 4'h0;
    tick();
    checks++;
    if (lfsr_data !== 4'hF) begin errors++; $display("FAIL reset_data got=%h exp=f", lfsr_data); end
    checks++;
    if (lfsr_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", lfsr_done); end
  endtask

  task automatic test_sequence();
    reset_n = 1'b1; load_seed = 1'b1; seed_data = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (lfsr_data !== 4'hF || lfsr_done !== 1'b0) begin
        errors++; $display("FAIL seed_hold got=%h/%b exp=f/0", lfsr_data, lfsr_done);
      end
    end
    load_seed = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++;
      if (lfsr_data !== exp_seq[(k-1)%15]) begin
        errors++; $display("FAIL seq_data shift=%0d got=%h exp=%h", k, lfsr_data, exp_seq[(k-1)%15]);
      end
      checks++;
      if (lfsr_done !== ((k % 15) == 0)) begin
        errors++; $display("FAIL seq_done shift=%0d got=%b exp=%b", k, lfsr_done, (k % 15) == 0);
      end
    end
  endtask

  task automatic test_zero_seed();
    load_seed = 1'b1; seed_data = 4'h0;
    tick();
    checks++;
    if (lfsr_data !== 4'h1 || lfsr_done !== 1'b0) begin
      errors++; $display("FAIL zero_load got=%h/%b exp=1/0", lfsr_data, lfsr_done);
    end
    load_seed = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (lfsr_data !== exp_seq[(3+k)%15] || lfsr_data === 4'h0) begin
        errors++; $display("FAIL zero_seq shift=%0d got=%h exp=%h", k, lfsr_data, exp_seq[(3+k)%15]);
      end
      checks++;
      if (lfsr_done !== (k == 15)) begin
        errors++; $display("FAIL zero_done shift=%0d got=%b exp=%b", k, lfsr_done, k == 15);
      end
    end
  endtask

  task automatic test_load_priority();
    load_seed = 1'b1; seed_data = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (lfsr_data !== 4'h5 || lfsr_done !== 1'b0) begin
        errors++; $display("FAIL load_wins edge=%0d got=%h/%b exp=5/0", i, lfsr_data, lfsr_done);
      end
    end
    load_seed = 1'b0;
    for (int k = 1; k <= 14; k++) tick();
    checks++;
    if (lfsr_data !== 4'hA) begin errors++; $display("FAIL pre_reload got=%h exp=a", lfsr_data); end
    load_seed = 1'b1; seed_data = 4'hA;
    tick();
    checks++;
    if (lfsr_data !== 4'hA || lfsr_done !== 1'b0) begin
      errors++; $display("FAIL load_same got=%h/%b exp=a/0", lfsr_data, lfsr_done);
    end
    load_seed = 1'b0;
  endtask

  task automatic test_reset_override();
    load_seed = 1'b1; seed_data = 4'h6;
    tick();
    load_seed = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    load_seed = 1'b1; seed_data = 4'h6; reset_n = 1'b0;
    tick();
    checks++;
    if (lfsr_data !== 4'hF || lfsr_done !== 1'b0) begin
      errors++; $display("FAIL reset_override got=%h/%b exp=f/0", lfsr_data, lfsr_done);
    end
    reset_n = 1'b1; load_seed = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (lfsr_data !== exp_seq[k-1] || lfsr_done !== (k == 15)) begin
        errors++; $display("FAIL post_reset shift=%0d got=%h/%b exp=%h/%b",
                           k, lfsr_data, lfsr_done, exp_seq[k-1], k == 15);
      end
    end
  endtask

  task automatic test_period(input int n);
    int period;
    bit repeat_free;
    sel_n = n; load_w = 1'b1; seed_w = 32'h1;
    tick();
    checks++;
    if (obs_data !== 32'h1) begin errors++; $display("FAIL period_load n=%0d got=%h exp=1", n, obs_data); end
    load_w = 1'b0;
    for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    period = 0;
    repeat_free = 1'b1;
    for (int k = 1; k <= (1 << n) + 2; k++) begin
      tick();
      if (obs_done) begin
        period = k;
        break;
      end
      if (obs_data == 32'h0 || seen[obs_data[11:0]]) repeat_free = 1'b0;
      seen[obs_data[11:0]] = 1'b1;
    end
    checks++;
    if (period !== (1 << n) - 1) begin
      errors++; $display("FAIL period n=%0d got=%0d exp=%0d", n, period, (1 << n) - 1);
    end
    checks++;
    if (!repeat_free) begin errors++; $display("FAIL no_repeat n=%0d got=repeat exp=unique", n); end
    checks++;
    if (obs_data !== 32'h1) begin errors++; $display("FAIL period_end n=%0d got=%h exp=1", n, obs_data); end
  endtask

  task automatic test_wide();
    logic [31:0] exp_w [4] = '{32'h3, 32'h6, 32'hD, 32'h1B};
    bit ok;
    sel_n = 32; load_w = 1'b1; seed_w = 32'h1;
    tick();
    load_w = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs_data !== exp_w[k]) begin
        errors++; $display("FAIL wide_seq shift=%0d got=%h exp=%h", k + 1, obs_data, exp_w[k]);
      end
    end
    ok = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (obs_done || obs_data == 32'h0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wide_run got=early_done_or_zero exp=clean"); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_zero_seed();
    test_load_priority();
    test_reset_override();
    test_period(2);
    test_period(3);
    test_period(7);
    test_period(12);
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
